four_bits_loader: RTL and testbench
===================================

Name: four_bits_loader

Overview:
Load-and-run controller for the four_bits core. A host pushes instruction words through a valid/ready interface into a small FIFO. The block replays each word onto the core's instruc/enable programming pins with guaranteed setup, strobe and gap timing. After the program is loaded, a start command switches to run mode, where the block issues periodic pc_tick strobes that drive the core's program-counter clock domain.

Parameters:
IW, 5, instruction width (matches core instruc)
PROG_DEPTH, 16, max words per program
FIFO_DEPTH, 4, host-side buffer entries (power of 2)
SETUP_CYC, 2, cycles instruc is stable before enable rises (>=1)
STROBE_CYC, 2, cycles enable is held high (>=1)
GAP_CYC, 2, cycles enable is low after the strobe, before the next word (>=1)
PC_DIV, 3, clk cycles per pc_tick in run mode (>=2)

Ports:
clk  in  1  system clock, all logic rising-edge
clear  in  1  reset, asynchronous, active-high
host_data  in  IW  instruction word from host
host_valid  in  1  host_data valid
host_ready  out  1  block accepts host_data this cycle
start  in  1  single-cycle pulse: begin run mode
halt  in  1  single-cycle pulse: leave run mode
instruc  out  IW  word presented to core
enable  out  1  core program-write strobe
pc_tick  out  1  one-cycle pulse per core PC step
loaded_count  out  $clog2(PROG_DEPTH)+1  words strobed into core
prog_full  out  1  accepted words == PROG_DEPTH
running  out  1  FSM in RUN

Behaviour:
- Reset (clear high, asynchronous):
  - instruc=0, enable=0, pc_tick=0, loaded_count=0, running=0.
  - FIFO emptied, accepted counter=0, FSM=IDLE.
  - host_ready=1 from the first cycle after clear deasserts.
- Accept:
  - host_ready = !fifo_full && (accepted < PROG_DEPTH) && state!=RUN. Combinational, and independent of a same-cycle pop.
  - A transfer occurs when host_valid && host_ready at a rising edge; accepted increments.
  - prog_full = (accepted == PROG_DEPTH).
  - Words reach the core in FIFO order.
- FSM states: IDLE, SETUP, STROBE, GAP, RUN.
  - IDLE:
    - If fifo non-empty: pop; instruc <= head on the same edge; go to SETUP.
    - Else if start && loaded_count>0: go to RUN.
    - Start with loaded_count==0, or with the FIFO non-empty, is ignored; it is not queued.
  - SETUP: enable=0 for SETUP_CYC cycles, then STROBE.
  - STROBE: enable=1 for exactly STROBE_CYC cycles, then GAP.
  - GAP:
    - enable=0 for GAP_CYC cycles.
    - On exit, loaded_count increments and the FSM returns to IDLE.
    - With defaults, back-to-back words have a period of 7 cycles (IDLE 1 + 2 + 2 + 2).
  - RUN:
    - running=1; internal divider starts at 0.
    - pc_tick=1 for one cycle each time the divider reaches PC_DIV-1, then the divider wraps to 0. The first tick occurs PC_DIV cycles after entry.
    - halt: go to IDLE on the next edge; loaded_count and accepted clear to 0 so a new program can be loaded.
  - start and halt together in RUN: halt wins.
  - halt outside RUN: ignored.
  - start inside RUN: ignored.
- Outputs and timing:
  - instruc is registered and holds its value until the next pop.
  - enable and pc_tick are registered, glitch-free, and never high in the same cycle.
  - loaded_count saturates at PROG_DEPTH by construction: at most PROG_DEPTH words are accepted.
- clear mid-operation:
  - Any state returns immediately (asynchronously) to IDLE with all outputs at reset values.
  - An enable pulse in progress is truncated.

Test Plan:
1. Assert clear for 1 cycle, then release -> instruc=0, enable=0, pc_tick=0, loaded_count=0, running=0, host_ready=1.
2. Push 5'b11000 once -> instruc=11000 one edge after the FIFO becomes non-empty; enable rises 2 cycles later and is high exactly 2 cycles; loaded_count=1 after GAP.
3. Hold host_valid with 01101, 01000, 00011, 11101, 00000 -> host_ready drops while 4 are buffered; 5 enable pulses at a 7-cycle period in push order; loaded_count=5.
4. Stream 17 words -> exactly 16 accepted; prog_full=1 and host_ready=0 after the 16th; loaded_count reaches 16; the 17th word is never presented.
5. After load, pulse start -> running=1; pc_tick high on cycles 3, 6, 9 after entry. Pulse start+halt together -> IDLE, loaded_count=0, host_ready=1. start with loaded_count=0 -> stays IDLE.
6. Assert clear in the middle of the STROBE phase -> enable falls with clear, without waiting for a clk edge; FIFO empty; a subsequent push loads normally.

Source files
------------

// File: rtl/four_bits_loader.sv
// Load-and-run controller for the four_bits core: buffers host words in a FIFO,
// replays them onto instruc/enable with fixed setup/strobe/gap timing, then clocks the PC.
module four_bits_loader #(
    parameter int IW         = 5,
    parameter int PROG_DEPTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2,
    parameter int GAP_CYC    = 2,
    parameter int PC_DIV     = 3
) (
    input  logic                        clk,
    input  logic                        clear,
    input  logic [IW-1:0]               host_data,
    input  logic                        host_valid,
    output logic                        host_ready,
    input  logic                        start,
    input  logic                        halt,
    output logic [IW-1:0]               instruc,
    output logic                        enable,
    output logic                        pc_tick,
    output logic [$clog2(PROG_DEPTH):0] loaded_count,
    output logic                        prog_full,
    output logic                        running
);

    localparam int CW   = $clog2(PROG_DEPTH) + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXC = (SETUP_CYC > STROBE_CYC) ?
                          ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                          ((STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC);
    localparam int TW   = $clog2(MAXC + 1);
    localparam int DW   = $clog2(PC_DIV);

    localparam logic [TW-1:0] SETUP_LAST  = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] STROBE_LAST = TW'(STROBE_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYC - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(PC_DIV - 1);
    localparam logic [CW-1:0] PROG_MAX    = CW'(PROG_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, RUN} state_t;

    state_t         state;
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [IW-1:0]  mem [FIFO_DEPTH];
    logic [CW-1:0]  accepted;
    logic [TW-1:0]  tcnt;
    logic [DW-1:0]  div;
    logic           fifo_empty, fifo_full, push;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign host_ready = !fifo_full && (accepted < PROG_MAX) && (state != RUN);
    assign push       = host_valid && host_ready;
    assign prog_full  = (accepted == PROG_MAX);

    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= host_data;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            accepted     <= '0;
            tcnt         <= '0;
            div          <= '0;
            instruc      <= '0;
            enable       <= 1'b0;
            pc_tick      <= 1'b0;
            loaded_count <= '0;
            running      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                accepted <= accepted + 1'b1;
            end
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (!fifo_empty) begin
                        instruc <= mem[rd_ptr[AW-1:0]];
                        rd_ptr  <= rd_ptr + 1'b1;
                        state   <= SETUP;
                    end else if (start && loaded_count != '0) begin
                        div     <= '0;
                        running <= 1'b1;
                        state   <= RUN;
                    end
                end
                SETUP: begin
                    if (tcnt == SETUP_LAST) begin
                        tcnt   <= '0;
                        enable <= 1'b1;
                        state  <= STROBE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                STROBE: begin
                    if (tcnt == STROBE_LAST) begin
                        tcnt   <= '0;
                        enable <= 1'b0;
                        state  <= GAP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (tcnt == GAP_LAST) begin
                        tcnt         <= '0;
                        loaded_count <= loaded_count + 1'b1;
                        state        <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        pc_tick      <= 1'b0;
                        running      <= 1'b0;
                        loaded_count <= '0;
                        accepted     <= '0;
                        div          <= '0;
                        state        <= IDLE;
                    end else if (div == DIV_LAST) begin
                        pc_tick <= 1'b1;
                        div     <= '0;
                    end else begin
                        pc_tick <= 1'b0;
                        div     <= div + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_four_bits_loader.sv
// Directed bench for four_bits_loader: pushed words go into a scoreboard queue and
// a monitor pops/compares them on every enable rising edge, also checking strobe width.
module tb_four_bits_loader;

    logic       clk, clear;
    logic [4:0] host_data;
    logic       host_valid, host_ready, start, halt;
    logic [4:0] instruc;
    logic       enable, pc_tick;
    logic [4:0] loaded_count;
    logic       prog_full, running;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [4:0] exp_q[$];
    int         rise_t[$];
    bit         trunc_ok = 0;

    four_bits_loader dut (
        .clk(clk), .clear(clear), .host_data(host_data), .host_valid(host_valid),
        .host_ready(host_ready), .start(start), .halt(halt), .instruc(instruc),
        .enable(enable), .pc_tick(pc_tick), .loaded_count(loaded_count),
        .prog_full(prog_full), .running(running)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    logic en_q  = 0;
    int   width = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (enable && !en_q) begin
            rise_t.push_back(cyc);
            width = 0;
            chk("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("word_order", instruc, exp_q.pop_front());
        end
        if (enable) width++;
        if (!enable && en_q) begin
            if (!trunc_ok) chk("strobe_width", width, 2);
            trunc_ok = 0;
        end
        if (enable && pc_tick) chk("en_tick_excl", 1, 0);
        en_q = enable;
    end

    task automatic push(input logic [4:0] w);
        int n = 0;
        @(negedge clk);
        host_data  = w;
        host_valid = 1;
        while (!host_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!host_ready) begin
            chk("push_timeout", host_ready, 1);
            host_valid = 0;
        end else begin
            @(posedge clk);
            exp_q.push_back(w);
            #1 host_valid = 0;
        end
    endtask

    task automatic wait_loaded(input logic [4:0] target, input int bound);
        int n = 0;
        while (loaded_count !== target && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("loaded_count", loaded_count, target);
    endtask

    task automatic pulse(input bit s, input bit h);
        @(negedge clk);
        start = s;
        halt  = h;
        @(posedge clk);
        #1;
        start = 0;
        halt  = 0;
    endtask

    task automatic run_halt();
        pulse(1, 0);
        chk("run_entered", running, 1);
        pulse(0, 1);
        chk("halt_clears", loaded_count, 0);
    endtask

    initial begin
        bit saw;
        clear = 1; host_data = 0; host_valid = 0; start = 0; halt = 0;

        // 1: reset values
        @(posedge clk);
        @(negedge clk) clear = 0;
        @(posedge clk);
        #1;
        chk("rst_instruc", instruc, 0);
        chk("rst_enable", enable, 0);
        chk("rst_pc_tick", pc_tick, 0);
        chk("rst_loaded", loaded_count, 0);
        chk("rst_running", running, 0);
        chk("rst_host_ready", host_ready, 1);

        // 2: single word timing
        push(5'b11000);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) chk("t2_instruc", instruc, 5'b11000);
            chk("t2_enable", enable, (k == 3 || k == 4));
            if (k == 6) chk("t2_loaded_pre", loaded_count, 0);
            if (k == 7) chk("t2_loaded", loaded_count, 1);
        end

        // 5: run mode, ticks, halt priority, start ignored when empty
        pulse(1, 0);
        chk("t5_running", running, 1);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            chk("t5_pc_tick", pc_tick, (k % 3 == 0));
        end
        pulse(1, 1);
        chk("t5_halt_running", running, 0);
        chk("t5_halt_loaded", loaded_count, 0);
        chk("t5_halt_ready", host_ready, 1);
        pulse(1, 0);
        @(posedge clk);
        #1;
        chk("t5_start_empty", running, 0);

        // 3: five words streamed back to back
        rise_t.delete();
        push(5'b01101);
        push(5'b01000);
        push(5'b00011);
        push(5'b11101);
        push(5'b00000);
        chk("t3_ready_full", host_ready, 0);
        wait_loaded(5, 100);
        chk("t3_pulses", rise_t.size(), 5);
        if (rise_t.size() == 5)
            for (int i = 1; i < 5; i++) chk("t3_period", rise_t[i] - rise_t[i-1], 7);
        chk("t3_drained", exp_q.size(), 0);
        run_halt();

        // 4: 17 words offered, 16 accepted
        for (int i = 0; i < 16; i++) push(5'(i * 3 + 1));
        chk("t4_prog_full", prog_full, 1);
        chk("t4_ready", host_ready, 0);
        saw = 0;
        @(negedge clk);
        host_data  = 5'b11111;
        host_valid = 1;
        for (int n = 0; n < 400 && loaded_count != 16; n++) begin
            @(negedge clk);
            if (host_ready) saw = 1;
        end
        host_valid = 0;
        chk("t4_17th_refused", saw, 0);
        chk("t4_loaded", loaded_count, 16);
        chk("t4_drained", exp_q.size(), 0);
        run_halt();

        // 6: clear during strobe
        push(5'b10101);
        for (int n = 0; n < 20 && !enable; n++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_in_strobe", enable, 1);
        trunc_ok = 1;
        #2 clear = 1;
        #1;
        chk("t6_enable_async", enable, 0);
        chk("t6_instruc_async", instruc, 0);
        chk("t6_loaded_async", loaded_count, 0);
        @(negedge clk) clear = 0;
        chk("t6_ready", host_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_fifo_empty", enable, 0);
        push(5'b01110);
        wait_loaded(1, 40);
        chk("t6_drained", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
